// File: rtl/sv_video_out_if.sv
// Video stream bundle between the LCD controller and the colour/ghosting output stage.
// The master drives shades and timing; the slave returns RGB and aligned timing.
interface sv_video_out_if;
  logic [1:0] pixel;
  logic       pix_ce;
  logic       hsync;
  logic       vsync;
  logic       hblank;
  logic       vblank;
  logic       ghost_en;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       hs_out;
  logic       vs_out;
  logic       hb_out;
  logic       vb_out;
  logic       ce_out;

  modport master (
    output pixel, pix_ce, hsync, vsync, hblank, vblank, ghost_en,
    input  r, g, b, hs_out, vs_out, hb_out, vb_out, ce_out
  );

  modport slave (
    input  pixel, pix_ce, hsync, vsync, hblank, vblank, ghost_en,
    output r, g, b, hs_out, vs_out, hb_out, vb_out, ce_out
  );
endinterface

// File: rtl/sv_video_out.sv
// Shade-to-RGB output stage with optional previous-frame blending (LCD persistence).
// Two-cycle pipeline: sample + buffer read, then blend + buffer write + output registers.
module sv_video_out #(
  parameter int unsigned H_ACTIVE = 160,
  parameter int unsigned V_ACTIVE = 160,
  parameter logic [23:0] PAL0     = 24'hE0F8D0,
  parameter logic [23:0] PAL1     = 24'h88C070,
  parameter logic [23:0] PAL2     = 24'h346856,
  parameter logic [23:0] PAL3     = 24'h081820
) (
  input logic           clk_sys,
  input logic           reset_n,
  sv_video_out_if.slave vid
);

  localparam int unsigned Depth = H_ACTIVE * V_ACTIVE;
  localparam int unsigned MemAw = (Depth > 1) ? $clog2(Depth) : 1;

  logic [1:0] mem [Depth];

  logic [7:0]  x_q, y_q;
  logic        line_act_q, vb_prev_q, prev_valid_q;
  logic        s1_ce_q, s1_hs_q, s1_vs_q, s1_hb_q, s1_vb_q, s1_wr_q, s1_blend_q;
  logic [1:0]  s1_pix_q, rd_q;
  logic [14:0] s1_addr_q;
  logic [7:0]  r_q, g_q, b_q;
  logic        hs_q, vs_q, hb_q, vb_q, ce_q;

  logic        in_bounds;
  logic [14:0] addr;
  logic [7:0]  x_inc, y_inc;
  logic [23:0] cur_rgb, prv_rgb, rgb_d;

  function automatic logic [23:0] pal(input logic [1:0] s);
    logic [23:0] c;
    c = PAL0;
    unique case (s)
      2'd0: c = PAL0;
      2'd1: c = PAL1;
      2'd2: c = PAL2;
      2'd3: c = PAL3;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] c);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, c} + 9'd1;
    return s[8:1];
  endfunction

  always_comb begin
    in_bounds = ~vid.hblank && ~vid.vblank && (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);
    addr      = 15'(32'(y_q) * H_ACTIVE + 32'(x_q));
    x_inc     = (32'(x_q) < H_ACTIVE) ? x_q + 8'd1 : x_q;
    y_inc     = (32'(y_q) < V_ACTIVE) ? y_q + 8'd1 : y_q;
  end

  always_comb begin
    cur_rgb = pal(s1_pix_q);
    prv_rgb = pal(rd_q);
    if (s1_hb_q || s1_vb_q) begin
      rgb_d = '0;
    end else if (s1_blend_q) begin
      rgb_d = {avg(cur_rgb[23:16], prv_rgb[23:16]), avg(cur_rgb[15:8], prv_rgb[15:8]),
               avg(cur_rgb[7:0], prv_rgb[7:0])};
    end else begin
      rgb_d = cur_rgb;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      x_q          <= '0;
      y_q          <= '0;
      line_act_q   <= 1'b0;
      vb_prev_q    <= 1'b0;
      prev_valid_q <= 1'b0;
      s1_ce_q      <= 1'b0;
      s1_hs_q      <= 1'b0;
      s1_vs_q      <= 1'b0;
      s1_hb_q      <= 1'b0;
      s1_vb_q      <= 1'b0;
      s1_wr_q      <= 1'b0;
      s1_blend_q   <= 1'b0;
      s1_pix_q     <= '0;
      s1_addr_q    <= '0;
      rd_q         <= '0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      hb_q         <= 1'b0;
      vb_q         <= 1'b0;
      ce_q         <= 1'b0;
    end else begin
      s1_ce_q <= vid.pix_ce;
      ce_q    <= s1_ce_q;
      if (vid.pix_ce) begin
        s1_pix_q   <= vid.pixel;
        s1_hs_q    <= vid.hsync;
        s1_vs_q    <= vid.vsync;
        s1_hb_q    <= vid.hblank;
        s1_vb_q    <= vid.vblank;
        s1_wr_q    <= in_bounds;
        s1_blend_q <= in_bounds && vid.ghost_en && prev_valid_q;
        s1_addr_q  <= addr;
        if (in_bounds) begin
          rd_q <= mem[addr[MemAw-1:0]];
        end
        // y only reaches V_ACTIVE after every line saw an active sample
        if (vid.vblank && !vb_prev_q && (32'(y_q) == V_ACTIVE)) begin
          prev_valid_q <= 1'b1;
        end
        vb_prev_q <= vid.vblank;
        if (vid.hblank) begin
          x_q <= '0;
        end else if (!vid.vblank) begin
          x_q <= x_inc;
        end
        if (vid.vblank) begin
          y_q        <= '0;
          line_act_q <= 1'b0;
        end else if (vid.hblank) begin
          if (line_act_q) begin
            y_q <= y_inc;
          end
          line_act_q <= 1'b0;
        end else begin
          line_act_q <= 1'b1;
        end
      end
      if (s1_ce_q) begin
        {r_q, g_q, b_q} <= rgb_d;
        hs_q            <= s1_hs_q;
        vs_q            <= s1_vs_q;
        hb_q            <= s1_hb_q;
        vb_q            <= s1_vb_q;
      end
    end
  end

  // Write lands one cycle after the read, so the read sees the previous frame
  always_ff @(posedge clk_sys) begin
    if (s1_ce_q && s1_wr_q) begin
      mem[s1_addr_q[MemAw-1:0]] <= s1_pix_q;
    end
  end

  assign vid.r      = r_q;
  assign vid.g      = g_q;
  assign vid.b      = b_q;
  assign vid.hs_out = hs_q;
  assign vid.vs_out = vs_q;
  assign vid.hb_out = hb_q;
  assign vid.vb_out = vb_q;
  assign vid.ce_out = ce_q;

endmodule
